// File: rtl/add_seq_ctrl_if.sv
// Requester-side bundle for add_seq_ctrl: start/done handshake, operands and result.
// The optional `sub` signal exists only when ADDSEQ_SUB_EN is defined.
interface add_seq_ctrl_if #(
    parameter int NWORDS = 4
);
    localparam int W = 8 * NWORDS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef ADDSEQ_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

`ifdef ADDSEQ_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/add_seq_ctrl.sv
// Byte-serial wide adder sequencer driving one shared 8-bit adder, LSB byte first.
// Define ADDSEQ_SUB_EN to add a subtract mode (sub input: a - b via ~b and carry-in 1).
module add_seq_ctrl #(
    parameter int NWORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    add_seq_ctrl_if.slave      req,
    output logic [7:0]         add_x,
    output logic [7:0]         add_y,
    output logic               add_cin,
    input  logic [7:0]         add_sum,
    input  logic               add_cout
);
    // state  | meaning
    // S_IDLE | waiting for start, adder inputs held at 0
    // S_RUN  | one byte per cycle through the shared adder
    // S_DONE | result valid, done pulses; start accepted back-to-back
    localparam int W     = 8 * NWORDS;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef ADDSEQ_SUB_EN
    logic               sub_q, sub_d;
`endif

    logic [IDX_W+2:0]   bit_base;
    logic               last_byte;

    assign bit_base  = {idx_q, 3'b000};
    assign last_byte = (idx_q == IDX_W'(NWORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADDSEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef ADDSEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef ADDSEQ_SUB_EN
        sub_d   = sub_q;
`endif
        add_x   = 8'h00;
        add_y   = 8'h00;
        add_cin = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (req.start) begin
                    a_d     = req.a;
                    b_d     = req.b;
                    idx_d   = '0;
                    state_d = S_RUN;
`ifdef ADDSEQ_SUB_EN
                    sub_d   = req.sub;
                    carry_d = req.sub | req.cin;
`else
                    carry_d = req.cin;
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                add_x   = a_q[bit_base +: 8];
`ifdef ADDSEQ_SUB_EN
                add_y   = sub_q ? ~b_q[bit_base +: 8] : b_q[bit_base +: 8];
`else
                add_y   = b_q[bit_base +: 8];
`endif
                add_cin = carry_q;
                sum_d[bit_base +: 8] = add_sum;
                carry_d = add_cout;
                if (last_byte) begin
                    cout_d  = add_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req.busy = (state_q == S_RUN);
    assign req.done = (state_q == S_DONE);
    assign req.sum  = sum_q;
    assign req.cout = cout_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed plus randomized bench for add_seq_ctrl (NWORDS=4) with an arithmetic reference model.
module tb_add_seq_ctrl;
    localparam int NW = 4;

    logic       clk;
    logic       rst;
    logic [7:0] add_x, add_y, add_sum;
    logic       add_cin, add_cout;
    int         checks;
    int         errors;

    add_seq_ctrl_if #(.NWORDS(NW)) rif ();

    add_seq_ctrl #(.NWORDS(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (rif),
        .add_x    (add_x),
        .add_y    (add_y),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // shared 8-bit adder living in the parent
    logic [8:0] adder_full;
    assign adder_full = 9'(add_x) + 9'(add_y) + 9'(add_cin);
    assign add_sum    = adder_full[7:0];
    assign add_cout   = adder_full[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // carry entering byte i of A + B + c0, from plain integer arithmetic on the low bytes
    function automatic logic carry_into(input logic [31:0] av, input logic [31:0] bv,
                                        input logic c0, input int i);
        longint unsigned m, s;
        m = (64'd1 << (8 * i)) - 64'd1;
        s = (longint'(av) & m) + (longint'(bv) & m) + longint'(c0);
        return logic'((s >> (8 * i)) & 64'd1);
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic tc,
                         input logic ts, input int poke_cyc);
        logic [31:0]     beff;
        logic            c0;
        longint unsigned full;
        logic [31:0]     bbyte_src;
        beff = ts ? ~tbv : tbv;
        c0   = ts ? 1'b1 : tc;
        full = longint'(ta) + longint'(beff) + longint'(c0);
        rif.a     = ta;
        rif.b     = tbv;
        rif.cin   = tc;
`ifdef ADDSEQ_SUB_EN
        rif.sub   = ts;
`endif
        rif.start = 1'b1;
        tick();
        rif.start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            bbyte_src = beff >> (8 * i);
            chk("busy_run", 64'(rif.busy), 64'd1);
            chk("done_run", 64'(rif.done), 64'd0);
            chk("add_x", 64'(add_x), 64'((ta >> (8 * i)) & 32'hFF));
            chk("add_y", 64'(add_y), 64'(bbyte_src & 32'hFF));
            chk("add_cin", 64'(add_cin), 64'(carry_into(ta, beff, c0, i)));
            if (i == poke_cyc) begin
                rif.start = 1'b1;
                rif.a     = 32'd1;
                rif.b     = 32'd1;
                rif.cin   = 1'b0;
            end else begin
                rif.start = 1'b0;
            end
            tick();
        end
        rif.start = 1'b0;
        chk("done_pulse", 64'(rif.done), 64'd1);
        chk("busy_done", 64'(rif.busy), 64'd0);
        chk("sum", 64'(rif.sum), full & 64'hFFFF_FFFF);
        chk("cout", 64'(rif.cout), (full >> 32) & 64'd1);
        chk("add_x_done", 64'(add_x), 64'd0);
        tick();
        chk("done_one_cycle", 64'(rif.done), 64'd0);
        chk("sum_held", 64'(rif.sum), full & 64'hFFFF_FFFF);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc, rs;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        rif.start = 1'b0;
        rif.a     = '0;
        rif.b     = '0;
        rif.cin   = 1'b0;
`ifdef ADDSEQ_SUB_EN
        rif.sub   = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(rif.busy), 64'd0);
        chk("rst_done", 64'(rif.done), 64'd0);
        chk("rst_sum", 64'(rif.sum), 64'd0);
        chk("rst_cout", 64'(rif.cout), 64'd0);
        chk("rst_add_x", 64'(add_x), 64'd0);
        chk("rst_add_y", 64'(add_y), 64'd0);
        chk("rst_add_cin", 64'(add_cin), 64'd0);

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 99);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 99);
        chk("t2_sum_const", 64'(rif.sum), 64'h2345_678A);
        do_op(32'd255, 32'd255, 1'b0, 1'b0, 1);
        chk("t3_sum_const", 64'(rif.sum), 64'h0000_01FE);

        // abort mid-operation with reset
        rif.a = 32'hA5A5_A5A5; rif.b = 32'h0101_0101; rif.cin = 1'b1; rif.start = 1'b1;
        tick();
        rif.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(rif.busy), 64'd0);
        chk("abort_sum", 64'(rif.sum), 64'd0);
        chk("abort_cout", 64'(rif.cout), 64'd0);
        chk("abort_add_x", 64'(add_x), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_done", 64'(rif.done), 64'd0);
            tick();
        end
        do_op(32'h0000_1000, 32'h0000_0F00, 1'b0, 1'b0, 99);

        // back-to-back: start held through the done cycle
        rif.a = 32'd7; rif.b = 32'd11; rif.cin = 1'b1; rif.start = 1'b1;
        tick();
        for (int i = 0; i < NW; i++) begin
            chk("b2b_busy", 64'(rif.busy), 64'd1);
            tick();
        end
        chk("b2b_done1", 64'(rif.done), 64'd1);
        chk("b2b_sum1", 64'(rif.sum), 64'd19);
        rif.a = 32'd168; rif.b = 32'd66; rif.cin = 1'b1;
        tick();
        rif.start = 1'b0;
        chk("b2b_rerun_busy", 64'(rif.busy), 64'd1);
        chk("b2b_rerun_done", 64'(rif.done), 64'd0);
        chk("b2b_old_sum", 64'(rif.sum), 64'd19);
        for (int i = 1; i <= NW; i++) begin
            tick();
            chk("b2b_gap", 64'(rif.done), (i == NW) ? 64'd1 : 64'd0);
        end
        chk("b2b_sum2", 64'(rif.sum), 64'd235);
        chk("b2b_cout2", 64'(rif.cout), 64'd0);
        tick();

`ifdef ADDSEQ_SUB_EN
        do_op(32'd5, 32'd7, 1'b0, 1'b1, 99);
        chk("sub_neg", 64'(rif.sum), 64'hFFFF_FFFE);
        chk("sub_borrow", 64'(rif.cout), 64'd0);
        do_op(32'd7, 32'd5, 1'b1, 1'b1, 99);
        chk("sub_pos", 64'(rif.sum), 64'd2);
        chk("sub_noborrow", 64'(rif.cout), 64'd1);
`endif

        for (int k = 0; k < 24; k++) begin
            ra = $urandom();
            rb = $urandom();
            if (k % 6 == 0) ra = 32'hFFFF_FFFF;
            if (k % 6 == 3) rb = ~ra;
            rc = 1'($urandom_range(0, 1));
`ifdef ADDSEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, rc, rs, int'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
